// File: rtl/booth_r4_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier: FSM states,
// digit-decode field positions and the digit-count helper.
package booth_r4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the {neg, two, zero} digit code.
  localparam int DIG_NEG  = 2;
  localparam int DIG_TWO  = 1;
  localparam int DIG_ZERO = 0;

  typedef logic [2:0] digit_t;

  // Unsigned operands need one extra digit to absorb the zero-extended MSB.
  function automatic int calc_ndig(input int width, input int is_signed);
    return (is_signed != 0) ? width / 2 : width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_mult_if.sv
// Start/ready handshake and operand/result bus of the Booth multiplier.
interface booth_r4_mult_if #(
  parameter int WIDTH = 8
);
  logic                   start;
  logic [WIDTH-1:0]       x_value;
  logic [WIDTH-1:0]       y_value;
  logic                   busy;
  logic                   ready;
  logic [2*WIDTH-1:0]     total_product;

  modport master (
    output start, x_value, y_value,
    input  busy, ready, total_product
  );

  modport slave (
    input  start, x_value, y_value,
    output busy, ready, total_product
  );
endinterface

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth recoder: one multiplier triplet in, {neg, two, zero} out.
module booth_r4_digit_enc
  import booth_r4_pkg::*;
(
  input  logic [2:0] triplet,
  output digit_t     digit
);

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    digit           = '0;
    digit[DIG_NEG]  = triplet[2];
    digit[DIG_TWO]  = (triplet == 3'b011) || (triplet == 3'b100);
    digit[DIG_ZERO] = (triplet == 3'b000) || (triplet == 3'b111);
  end

endmodule

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 (modified Booth) multiplier, one digit per cycle.
// Optional `BOOTH_R4_EARLY_EXIT_EN skips trailing zero digits.
module booth_r4_mult
  import booth_r4_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 1
) (
  input  logic            clock,
  input  logic            reset,
  booth_r4_mult_if.slave  bus
);

  localparam int NDIG = calc_ndig(WIDTH, SIGNED);
  localparam int XW   = WIDTH + 3;
  localparam int AW   = 2 * WIDTH + 2;
  localparam int CW   = $clog2(NDIG + 1);

  state_t              state, state_nxt;
  logic [XW-1:0]       x_ext;
  logic [AW-1:0]       y_ext;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       mag;
  logic [AW-1:0]       term;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH-1:0]  product;
  digit_t              digit;
  logic                accept;
  logic                finish;
  logic                busy;
  logic                ready;
  logic                x_fill;
  logic                y_fill;
  logic                unused_acc_msb;

  assign x_fill = (SIGNED != 0) ? bus.x_value[WIDTH-1] : 1'b0;
  assign y_fill = (SIGNED != 0) ? bus.y_value[WIDTH-1] : 1'b0;
  assign accept = bus.start && (state != CALC);

  // x_ext is shifted right two bits per digit, so bits [2:0] always hold
  // the current triplet and bit 0 is extended-multiplier bit 2i-1.
  booth_r4_digit_enc u_digit_enc (
    .triplet (x_ext[2:0]),
    .digit   (digit)
  );

  always_comb begin
    mag  = digit[DIG_TWO] ? {y_ext[AW-2:0], 1'b0} : y_ext;
    term = '0;
    if (!digit[DIG_ZERO]) begin
      term = digit[DIG_NEG] ? (~mag + AW'(1)) : mag;
    end
  end

`ifdef BOOTH_R4_EARLY_EXIT_EN
  // Remaining bits all equal means every remaining digit decodes to zero.
  assign finish = (cnt == CW'(NDIG)) ||
                  ((cnt != '0) && ((x_ext == '0) || (&x_ext)));
`else
  assign finish = (cnt == CW'(NDIG));
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (bus.start) state_nxt = CALC;
      CALC:       if (finish)    state_nxt = DONE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    ready = 1'b0;
    case (state)
      CALC:    busy  = 1'b1;
      DONE:    ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_ext   <= '0;
      y_ext   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      x_ext <= {{2{x_fill}}, bus.x_value, 1'b0};
      y_ext <= {{(WIDTH + 2){y_fill}}, bus.y_value};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == CALC) begin
      if (finish) begin
        product <= acc[2*WIDTH-1:0];
      end else begin
        acc   <= acc + term;
        x_ext <= {{2{x_ext[XW-1]}}, x_ext[XW-1:2]};
        y_ext <= {y_ext[AW-3:0], 2'b00};
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // The two guard bits above the product are never observable.
  assign unused_acc_msb = ^acc[AW-1:2*WIDTH];

  assign bus.busy          = busy;
  assign bus.ready         = ready;
  assign bus.total_product = product;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench: 8-bit signed, 8-bit unsigned and 16-bit signed
// instances checked against plain integer multiplication.
`timescale 1ns/1ps
module tb_booth_r4_mult;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  booth_r4_mult_if #(.WIDTH(8))  if8s ();
  booth_r4_mult_if #(.WIDTH(8))  if8u ();
  booth_r4_mult_if #(.WIDTH(16)) if16s ();

  booth_r4_mult #(.WIDTH(8),  .SIGNED(1)) u_s8  (.clock(clock), .reset(reset), .bus(if8s));
  booth_r4_mult #(.WIDTH(8),  .SIGNED(0)) u_u8  (.clock(clock), .reset(reset), .bus(if8u));
  booth_r4_mult #(.WIDTH(16), .SIGNED(1)) u_s16 (.clock(clock), .reset(reset), .bus(if16s));

  // Device selector: 0 = signed 8, 1 = unsigned 8, 2 = signed 16.
  function automatic int dw(input int d);
    return (d == 2) ? 16 : 8;
  endfunction

  function automatic bit dsg(input int d);
    return d != 1;
  endfunction

  function automatic logic rd_ready(input int d);
    case (d)
      0:       return if8s.ready;
      1:       return if8u.ready;
      default: return if16s.ready;
    endcase
  endfunction

  function automatic logic rd_busy(input int d);
    case (d)
      0:       return if8s.busy;
      1:       return if8u.busy;
      default: return if16s.busy;
    endcase
  endfunction

  function automatic logic [31:0] rd_prod(input int d);
    case (d)
      0:       return {16'h0, if8s.total_product};
      1:       return {16'h0, if8u.total_product};
      default: return if16s.total_product;
    endcase
  endfunction

  task automatic drive(input int d, input logic s, input logic [15:0] x, input logic [15:0] y);
    case (d)
      0: begin if8s.start = s;  if8s.x_value = x[7:0];  if8s.y_value = y[7:0];  end
      1: begin if8u.start = s;  if8u.x_value = x[7:0];  if8u.y_value = y[7:0];  end
      default: begin if16s.start = s; if16s.x_value = x; if16s.y_value = y; end
    endcase
  endtask

  // Reference: interpret the operands at the device's width and signedness,
  // multiply as integers, keep the low 2*WIDTH bits.
  function automatic logic [31:0] ref_prod(input int d, input logic [15:0] x, input logic [15:0] y);
    int     w = dw(d);
    longint a, b, p;
    a = longint'(x) & ((longint'(1) << w) - 1);
    b = longint'(y) & ((longint'(1) << w) - 1);
    if (dsg(d)) begin
      if (a >= (longint'(1) << (w - 1))) a -= (longint'(1) << w);
      if (b >= (longint'(1) << (w - 1))) b -= (longint'(1) << w);
    end
    p = a * b;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int d, input int lat);
    int nd = dsg(d) ? dw(d) / 2 : dw(d) / 2 + 1;
`ifdef BOOTH_R4_EARLY_EXIT_EN
    check({tag, "/lat_range"}, 64'((lat >= 2) && (lat <= nd + 1)), 64'd1);
`else
    check({tag, "/lat"}, 64'(lat), 64'(nd + 1));
`endif
  endtask

  // Waits (bounded) for ready; lat counts clock edges since the accepting edge.
  task automatic wait_ready(input int d, input string tag, output int lat);
    bit done = 1'b0;
    lat = 0;
    while (!done && lat < 64) begin
      @(posedge clock); #1;
      lat++;
      done = (rd_ready(d) === 1'b1);
    end
    check({tag, "/done"}, 64'(done), 64'd1);
  endtask

  task automatic run_op(input int d, input logic [15:0] x, input logic [15:0] y,
                        input string tag, output logic [31:0] prod, output int lat);
    drive(d, 1'b1, x, y);
    @(posedge clock); #1;
    drive(d, 1'b0, 16'h0, 16'h0);
    check({tag, "/busy"}, 64'(rd_busy(d)), 64'd1);
    wait_ready(d, tag, lat);
    check_lat(tag, d, lat);
    prod = rd_prod(d);
    check({tag, "/prod"}, 64'(prod), 64'(ref_prod(d, x, y)));
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] held;
    logic [15:0] rx, ry;
    int          lat;

    reset = 1'b0;
    drive(0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 16'h0, 16'h0);
    drive(2, 1'b0, 16'h0, 16'h0);
    #12;
    check("rst/busy",  64'(rd_busy(0)),  64'd0);
    check("rst/ready", 64'(rd_ready(0)), 64'd0);
    check("rst/prod",  64'(rd_prod(0)),  64'd0);
    check("rst/prod16", 64'(rd_prod(2)), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    run_op(0, 16'h0080, 16'h0080, "s8_80x80", p, lat);
    check("s8_80x80/const", 64'(p), 64'h4000);
    run_op(0, 16'h007F, 16'h0081, "s8_7Fx81", p, lat);
    check("s8_7Fx81/const", 64'(p), 64'hC0FF);
    run_op(0, 16'h00FF, 16'h00FF, "s8_FFxFF", p, lat);
    check("s8_FFxFF/const", 64'(p), 64'h0001);
    run_op(1, 16'h00FF, 16'h00FF, "u8_FFxFF", p, lat);
    check("u8_FFxFF/const", 64'(p), 64'hFE01);
    run_op(1, 16'h0000, 16'h00A5, "u8_00xA5", p, lat);
    check("u8_00xA5/const", 64'(p), 64'h0000);

    // Start held high with operands changing every cycle while busy.
    drive(0, 1'b1, 16'h0035, 16'h00C7);
    @(posedge clock); #1;
    lat = 0;
    while (rd_ready(0) !== 1'b1 && lat < 64) begin
      drive(0, 1'b1, 16'($urandom), 16'($urandom));
      @(posedge clock); #1;
      lat++;
    end
    check("busy_ign/done", 64'(rd_ready(0)), 64'd1);
    held = rd_prod(0);
    check("busy_ign/prod", 64'(held), 64'(ref_prod(0, 16'h0035, 16'h00C7)));
    drive(0, 1'b1, 16'h009A, 16'h003B);
    @(posedge clock); #1;
    drive(0, 1'b0, 16'h0, 16'h0);
    check("b2b/ready_drop", 64'(rd_ready(0)), 64'd0);
    check("b2b/prod_held",  64'(rd_prod(0)),  64'(held));
    wait_ready(0, "b2b", lat);
    check("b2b/prod", 64'(rd_prod(0)), 64'(ref_prod(0, 16'h009A, 16'h003B)));

    // Asynchronous reset pulse in the middle of a calculation.
    drive(0, 1'b1, 16'h005A, 16'h006B);
    @(posedge clock); #1;
    drive(0, 1'b0, 16'h0, 16'h0);
    @(posedge clock); #1;
    check("midrst/busy_before", 64'(rd_busy(0)), 64'd1);
    #3 reset = 1'b0;
    #0.5;
    check("midrst/busy",  64'(rd_busy(0)),  64'd0);
    check("midrst/ready", 64'(rd_ready(0)), 64'd0);
    check("midrst/prod",  64'(rd_prod(0)),  64'd0);
    #0.5 reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    check("midrst/idle_ready", 64'(rd_ready(0)), 64'd0);
    check("midrst/idle_busy",  64'(rd_busy(0)),  64'd0);
    run_op(0, 16'h00C3, 16'h002D, "midrst/after", p, lat);

    run_op(2, 16'h8000, 16'h8000, "s16_min_min", p, lat);
    run_op(2, 16'h7FFF, 16'h8000, "s16_max_min", p, lat);
    run_op(2, 16'hFFFF, 16'hFFFF, "s16_m1_m1",   p, lat);
    run_op(2, 16'h7FFF, 16'h7FFF, "s16_max_max", p, lat);
    run_op(2, 16'h0000, 16'h1234, "s16_zero",    p, lat);
    run_op(2, 16'h0001, 16'h8000, "s16_one_min", p, lat);

    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      run_op(2, rx, ry, $sformatf("s16_rnd%0d", i), p, lat);
    end
    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom_range(0, 255));
      ry = 16'($urandom_range(0, 255));
      run_op(1, rx, ry, $sformatf("u8_rnd%0d", i), p, lat);
    end

`ifdef BOOTH_R4_EARLY_EXIT_EN
    ry = 16'($urandom);
    run_op(2, 16'h0001, ry, "early_x1", p, lat);
    check("early_x1/lat", 64'(lat), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
Parametrised sequential radix-4 (modified Booth) multiplier. It is the successor of the fixed 8-bit unsigned multiplier and adds generic operand width, signed/unsigned mode, an explicit busy/ready handshake and a fixed digit-per-cycle schedule. It sits in the datapath as a multi-cycle arithmetic unit driven by a controller over a start/ready handshake.

Parameters:
WIDTH, 8, operand width in bits; must be even and at least 4.
SIGNED, 1, 1 treats operands as two's complement; 0 treats them as unsigned.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (low clears all state immediately).
start  input  1  request; sampled only when busy=0.
x_value  input  WIDTH  multiplier; Booth-recoded.
y_value  input  WIDTH  multiplicand.
busy  output  1  high while a multiplication is in progress.
ready  output  1  high while total_product holds a completed result.
total_product  output  2*WIDTH  product, signed or unsigned per SIGNED.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, ready=0, total_product=0, iteration counter=0, internal operand registers=0. Reset mid-operation aborts the operation; no partial result is kept.
- Digits: NDIG = WIDTH/2 if SIGNED=1, else WIDTH/2+1.
- Extended multiplier: x_value with a 0 appended below the LSB. Above the MSB it is sign-extended (SIGNED=1) or zero-extended by 2 bits (SIGNED=0).
- The multiplicand is sign- or zero-extended to 2*WIDTH+2 bits.
- The internal accumulator is 2*WIDTH+2 bits. total_product takes the low 2*WIDTH bits, which are always exact.
- Digit i uses extended-multiplier bits [2i+1:2i-1]:
  - 000 and 111 map to 0.
  - 001 and 010 map to +Y.
  - 011 maps to +2Y.
  - 100 maps to -2Y.
  - 101 and 110 map to -Y.
  - The term is shifted left by 2i.
- States:
  - IDLE: start=1 latches x_value and y_value, clears the accumulator and counter, sets busy=1, sets ready=0, goes to CALC.
  - CALC: one digit is added per cycle. After digit NDIG-1 the state goes to DONE, and total_product is written with the final sum on that same edge.
  - DONE: busy=0, ready=1; total_product is held stable. start=1 behaves as in IDLE (back-to-back operation allowed).
- Latency: start sampled at edge k gives ready=1 after edge k+NDIG+1. The 8-bit signed case takes 5 cycles; the 8-bit unsigned case takes 6.
- start while busy=1 is ignored. Operand changes while busy=1 have no effect, because the operands are latched.
- total_product changes only on the final CALC edge or on reset. It is not cleared by a new start, but ready drops on the accepting edge.
- No combinational path from any input to any output.

Optional Feature:
BOOTH_R4_EARLY_EXIT_EN:
- Defined: in CALC, if all remaining extended-multiplier bits from 2i-1 upward are equal (all 0 or all 1), every remaining digit is 0. The block then writes the result and enters DONE on that edge, skipping those digits. Latency becomes variable, minimum 2 cycles from start to ready; the result is identical.
- Undefined: fixed latency NDIG+1 always.

Decomposition:
- Package booth_r4_pkg holds:
  - the state encoding constants IDLE, CALC and DONE;
  - digit-decode field constants (neg, two, zero);
  - a helper function computing NDIG from WIDTH and SIGNED.
- Sub-module booth_r4_digit_enc is a natural split. It is combinational: 3-bit triplet in, {neg, two, zero} out. It is used once per cycle by the main FSM.

Test Plan:
- WIDTH=8, SIGNED=1, x=8'h80, y=8'h80, pulse start -> ready=1 exactly 5 cycles after start edge, total_product=16'h4000.
- WIDTH=8, SIGNED=1, x=8'h7F, y=8'h81 -> total_product=16'hC0FF (-16129). Then x=y=8'hFF -> 16'h0001.
- WIDTH=8, SIGNED=0, x=y=8'hFF -> ready after 6 cycles, total_product=16'hFE01. x=8'h00, y=8'hA5 -> 16'h0000.
- Busy-start ignore: assert start and change x/y every cycle during CALC -> result equals product of operands latched at the accepting edge; back-to-back start in DONE gives correct second product.
- Reset mid-CALC (reset=0 for 1 ns, asynchronous to the clock) -> busy, ready and total_product go to 0 immediately, state=IDLE. The next start computes correctly.
- WIDTH=16, SIGNED=1, randomized 1000 operand pairs vs. reference model. With BOOTH_R4_EARLY_EXIT_EN, x=16'h0001 gives ready 2 cycles after start with correct product.
